// File: rtl/motor_pkg.sv
// Shared encodings for the motor_drive block: per-channel mode codes and
// channel state enum.
package motor_pkg;

  localparam logic [1:0] MODE_STOP  = 2'b00;
  localparam logic [1:0] MODE_FWD   = 2'b01;
  localparam logic [1:0] MODE_REV   = 2'b10;
  localparam logic [1:0] MODE_BRAKE = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    RAMP_DN = 3'd2,
    DEAD    = 3'd3,
    BRAKE   = 3'd4
  } ch_state_e;

  function automatic logic is_drive(input logic [1:0] m);
    return (m == MODE_FWD) || (m == MODE_REV);
  endfunction

endpackage

// File: rtl/motor_channel.sv
// One H-bridge channel: FSM, duty register, dead-time counter and PWM compare.
// Define MOTOR_RAMP_EN for ramped duty; otherwise duty jumps at each boundary.
module motor_channel
  import motor_pkg::*;
#(
  parameter int PWM_W     = 10,
  parameter int RAMP_STEP = 32,
  parameter int DEAD_CYC  = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       mode_i,
  input  logic [PWM_W-1:0] speed_i,
  input  logic [PWM_W-1:0] cnt_i,
  input  logic             bnd_i,
  output logic             pwm_o,
  output logic             in_a_o,
  output logic             in_b_o,
  output logic             busy_o
);

  localparam int              DW        = $clog2(DEAD_CYC + 1);
  localparam logic [PWM_W:0]  STEP      = (PWM_W+1)'(RAMP_STEP);
  localparam logic [DW-1:0]   DEAD_LOAD = DW'(DEAD_CYC - 1);

  ch_state_e        state_q, state_d;
  logic             fwd_q, fwd_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic [DW-1:0]    dead_q, dead_d;
  logic             pwm_q, pwm_d, in_a_q, in_a_d, in_b_q, in_b_d, busy_q, busy_d;
  logic             leave_s, brk_s, drv_s;

`ifdef MOTOR_RAMP_EN
  // Differences up to one step land exactly on target, so no overshoot or wrap.
  function automatic logic [PWM_W-1:0] ramp_toward(input logic [PWM_W-1:0] cur,
                                                   input logic [PWM_W-1:0] tgt);
    logic [PWM_W-1:0] r;
    if (tgt >= cur) begin
      if ({1'b0, tgt - cur} <= STEP) r = tgt;
      else                           r = cur + STEP[PWM_W-1:0];
    end else begin
      if ({1'b0, cur - tgt} <= STEP) r = tgt;
      else                           r = cur - STEP[PWM_W-1:0];
    end
    return r;
  endfunction
`endif

  // Next state; brake wins over transitions, transitions win over ramp updates.
  always_comb begin
    state_d = state_q;
    fwd_d   = fwd_q;
    duty_d  = duty_q;
    dead_d  = dead_q;
    leave_s = (mode_i != (fwd_q ? MODE_FWD : MODE_REV));
    if (mode_i == MODE_BRAKE) begin
      state_d = BRAKE;
      duty_d  = '0;
      dead_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          duty_d = '0;
          if (is_drive(mode_i)) begin
            state_d = RUN;
            fwd_d   = (mode_i == MODE_FWD);
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (leave_s) begin
            state_d = RAMP_DN;
`ifndef MOTOR_RAMP_EN
            duty_d  = '0;
`endif
          end else if (bnd_i) begin
`ifdef MOTOR_RAMP_EN
            duty_d = ramp_toward(duty_q, speed_i);
`else
            duty_d = speed_i;
`endif
          end else begin
            duty_d = duty_q;
          end
        end
        RAMP_DN: begin
          if (bnd_i && (duty_q == '0)) begin
            state_d = (mode_i == MODE_STOP) ? IDLE : DEAD;
            dead_d  = DEAD_LOAD;
          end else if (bnd_i) begin
            duty_d = ({1'b0, duty_q} > STEP) ? (duty_q - STEP[PWM_W-1:0]) : '0;
          end else begin
            duty_d = duty_q;
          end
        end
        DEAD: begin
          duty_d = '0;
          if (dead_q == '0) begin
            if (is_drive(mode_i)) begin
              state_d = RUN;
              fwd_d   = (mode_i == MODE_FWD);
            end else begin
              state_d = IDLE;
            end
          end else begin
            dead_d = dead_q - DW'(1);
          end
        end
        BRAKE: begin
          state_d = IDLE;
          duty_d  = '0;
          dead_d  = '0;
        end
        default: begin
          state_d = IDLE;
          duty_d  = '0;
          dead_d  = '0;
        end
      endcase
    end
  end

  // Pin values; brake shows on the clock right after mode 11 is seen.
  always_comb begin
    brk_s  = (mode_i == MODE_BRAKE) || (state_q == BRAKE);
    drv_s  = (state_q == RUN) || (state_q == RAMP_DN);
    pwm_d  = brk_s || (duty_q > cnt_i);
    in_a_d = brk_s || (drv_s && fwd_q);
    in_b_d = brk_s || (drv_s && !fwd_q);
    busy_d = (state_q == RAMP_DN) || (state_q == DEAD) ||
             ((state_q == RUN) && (duty_q != speed_i));
  end

  // State, duty, dead counter and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      fwd_q   <= 1'b0;
      duty_q  <= '0;
      dead_q  <= '0;
      pwm_q   <= 1'b0;
      in_a_q  <= 1'b0;
      in_b_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fwd_q   <= fwd_d;
      duty_q  <= duty_d;
      dead_q  <= dead_d;
      pwm_q   <= pwm_d;
      in_a_q  <= in_a_d;
      in_b_q  <= in_b_d;
      busy_q  <= busy_d;
    end
  end

  assign pwm_o  = pwm_q;
  assign in_a_o = in_a_q;
  assign in_b_o = in_b_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/motor_drive.sv
// N-channel H-bridge motor driver: shared PWM counter plus one motor_channel per
// motor. Ramped duty is enabled by defining MOTOR_RAMP_EN.
module motor_drive
  import motor_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int PWM_W     = 10,
  parameter int RAMP_STEP = 32,
  parameter int DEAD_CYC  = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*N_CH-1:0]       mode,
  input  logic [N_CH*PWM_W-1:0]   speed,
  output logic [N_CH-1:0]         pwm,
  output logic [N_CH-1:0]         in_a,
  output logic [N_CH-1:0]         in_b,
  output logic [N_CH-1:0]         busy
);

  logic [PWM_W-1:0] cnt_q;
  logic             bnd_s;

  // Free-running PWM period counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + PWM_W'(1);
    end
  end

  assign bnd_s = &cnt_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    motor_channel #(
      .PWM_W    (PWM_W),
      .RAMP_STEP(RAMP_STEP),
      .DEAD_CYC (DEAD_CYC)
    ) u_ch (
      .clk_i  (clk),
      .rst_i  (rst),
      .mode_i (mode[2*k+1:2*k]),
      .speed_i(speed[k*PWM_W +: PWM_W]),
      .cnt_i  (cnt_q),
      .bnd_i  (bnd_s),
      .pwm_o  (pwm[k]),
      .in_a_o (in_a[k]),
      .in_b_o (in_b[k]),
      .busy_o (busy[k])
    );
  end

endmodule

// File: tb/tb_motor_drive.sv
// Self-checking bench for motor_drive: directed scenarios plus randomized modes
// and speeds, checked every cycle against a behavioural channel model.
module tb_motor_drive;

  localparam int N_CH = 2, PWM_W = 4, RAMP_STEP = 4, DEAD_CYC = 8;
  localparam int MAXV = (1 << PWM_W) - 1;
`ifdef MOTOR_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [2*N_CH-1:0]     mode;
  logic [N_CH*PWM_W-1:0] speed;
  logic [N_CH-1:0]       pwm, in_a, in_b, busy;

  int checks = 0;
  int errors = 0;

  motor_drive #(.N_CH(N_CH), .PWM_W(PWM_W), .RAMP_STEP(RAMP_STEP), .DEAD_CYC(DEAD_CYC)) dut (
    .clk(clk), .rst(rst), .mode(mode), .speed(speed),
    .pwm(pwm), .in_a(in_a), .in_b(in_b), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: drive = +1/-1/0, winding = slowing before stop/reversal,
  // dead = coast clocks left, brake = braking.
  int m_cnt = 0;
  int m_duty[N_CH], m_drive[N_CH], m_dead[N_CH];
  bit m_wind[N_CH], m_brake[N_CH];
  bit e_pwm[N_CH], e_a[N_CH], e_b[N_CH], e_busy[N_CH];

  always @(posedge clk) begin
    for (int k = 0; k < N_CH; k++) begin
      int md, sp, want;
      bit bo, bnd;
      md  = int'(mode[2*k +: 2]);
      sp  = int'(speed[k*PWM_W +: PWM_W]);
      bnd = (m_cnt == MAXV);
      if (rst) begin
        m_duty[k] = 0; m_drive[k] = 0; m_dead[k] = 0; m_wind[k] = 0; m_brake[k] = 0;
        e_pwm[k] = 0; e_a[k] = 0; e_b[k] = 0; e_busy[k] = 0;
      end else begin
        bo        = (md == 3) || m_brake[k];
        e_pwm[k]  = bo || (m_duty[k] > m_cnt);
        e_a[k]    = bo || (m_drive[k] == 1);
        e_b[k]    = bo || (m_drive[k] == -1);
        e_busy[k] = m_wind[k] || (m_dead[k] > 0) || (m_drive[k] != 0 && m_duty[k] != sp);
        want      = (md == 1) ? 1 : (md == 2) ? -1 : 0;
        if (md == 3) begin
          m_brake[k] = 1; m_drive[k] = 0; m_wind[k] = 0; m_dead[k] = 0; m_duty[k] = 0;
        end else if (m_brake[k]) begin
          m_brake[k] = 0;
        end else if (m_dead[k] > 0) begin
          if (m_dead[k] == 1) begin
            m_dead[k]  = 0;
            m_drive[k] = want;
          end else begin
            m_dead[k]--;
          end
        end else if (m_drive[k] == 0) begin
          m_drive[k] = want;
        end else if (!m_wind[k]) begin
          if (want != m_drive[k]) begin
            m_wind[k] = 1;
            if (!RAMP) m_duty[k] = 0;
          end else if (bnd) begin
            if (!RAMP || (sp - m_duty[k] <= RAMP_STEP && m_duty[k] - sp <= RAMP_STEP))
              m_duty[k] = sp;
            else if (sp > m_duty[k])
              m_duty[k] += RAMP_STEP;
            else
              m_duty[k] -= RAMP_STEP;
          end
        end else if (bnd) begin
          if (m_duty[k] == 0) begin
            m_wind[k]  = 0;
            m_drive[k] = 0;
            if (md != 0) m_dead[k] = DEAD_CYC;
          end else begin
            m_duty[k] = (m_duty[k] > RAMP_STEP) ? m_duty[k] - RAMP_STEP : 0;
          end
        end
      end
    end
    m_cnt = rst ? 0 : (m_cnt + 1) % (MAXV + 1);
  end

  // Compare every output of every channel against the model each cycle.
  always @(negedge clk) begin
    for (int k = 0; k < N_CH; k++) begin
      check_eq($sformatf("pwm%0d", k),  int'(pwm[k]),  int'(e_pwm[k]));
      check_eq($sformatf("in_a%0d", k), int'(in_a[k]), int'(e_a[k]));
      check_eq($sformatf("in_b%0d", k), int'(in_b[k]), int'(e_b[k]));
      check_eq($sformatf("busy%0d", k), int'(busy[k]), int'(e_busy[k]));
    end
  end

  task automatic set_ch(input int k, input logic [1:0] m, input int s);
    mode[2*k +: 2]          = m;
    speed[k*PWM_W +: PWM_W] = PWM_W'(s);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_high(input int k, output int n);
    n = 0;
    for (int i = 0; i <= MAXV; i++) begin
      @(negedge clk);
      if (pwm[k]) n++;
    end
  endtask

  initial begin
    int hi, dead_n, r;
    bit seen_b;
    rst   = 1'b1;
    mode  = '0;
    speed = '0;
    set_ch(0, 2'b01, 12);
    set_ch(1, 2'b01, 12);
    wait_cyc(3);
    check_eq("reset_outs", int'({pwm, in_a, in_b, busy}), 0);
    rst = 1'b0;
    set_ch(1, 2'b00, 0);

    wait_cyc(16 * 5);
    count_high(0, hi);
    check_eq("fwd_duty12", hi, 12);
    check_eq("fwd_pins", int'({in_a[0], in_b[0]}), 2);
    check_eq("fwd_busy_low", int'(busy[0]), 0);

    set_ch(0, 2'b10, 12);
    dead_n = 0;
    seen_b = 1'b0;
    for (int i = 0; i < 300 && !seen_b; i++) begin
      @(negedge clk);
      if (in_b[0]) seen_b = 1'b1;
      else if (!in_a[0]) dead_n++;
    end
    check_eq("rev_reached", int'(seen_b), 1);
    check_eq("dead_len", dead_n, DEAD_CYC);
    wait_cyc(16 * 5);
    count_high(0, hi);
    check_eq("rev_duty12", hi, 12);

    set_ch(1, 2'b01, 15);
    wait_cyc(30);
    set_ch(1, 2'b11, 15);
    @(negedge clk);
    check_eq("brake_pins", int'({in_a[1], in_b[1], pwm[1]}), 7);
    wait_cyc(5);
    set_ch(1, 2'b01, 15);
    wait_cyc(16 * 6);
    count_high(1, hi);
    check_eq("after_brake_duty15", hi, 15);

    set_ch(0, 2'b01, 15);
    set_ch(1, 2'b10, 4);
    wait_cyc(16 * 8);
    count_high(0, hi);
    check_eq("indep_ch0", hi, 15);
    count_high(1, hi);
    check_eq("indep_ch1", hi, 4);

    for (int it = 0; it < 60; it++) begin
      for (int k = 0; k < N_CH; k++) begin
        r = int'($urandom_range(0, 9));
        set_ch(k, (r < 4) ? 2'b01 : (r < 7) ? 2'b10 : (r < 9) ? 2'b00 : 2'b11,
               int'($urandom_range(0, MAXV)));
      end
      if ($urandom_range(0, 14) == 0) begin
        rst = 1'b1;
        wait_cyc(int'($urandom_range(1, 2)));
        rst = 1'b0;
      end
      wait_cyc(int'($urandom_range(1, 80)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
